fetch_stage: RTL and testbench

//  IF stage of the RV32I 5-stage pipeline: owns the PC and fetches from instruction memory.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage owning the PC, single-outstanding fetch handshake and IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN adds a registered o_misalign flag for misaligned redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_en,
  input  logic        i_flush,
  input  logic [31:0] i_branch_target,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic [31:0] i_instr_rdata,
  input  logic        i_instr_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        o_misalign
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t      state;
  logic [31:0] pc, hold_pc, hold_instr;
  logic        xfer;
  assign xfer = o_instr_req && i_instr_ready;
  assign o_instr_addr = pc;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      o_instr_req <= 1'b0;
      o_if_pc     <= RESET_PC;
      o_if_instr  <= NOP_INSTR;
      o_if_valid  <= 1'b0;
      hold_pc     <= RESET_PC;
      hold_instr  <= NOP_INSTR;
    end else if (i_flush) begin
      state       <= REQ;
      pc          <= i_branch_target & 32'hFFFF_FFFC;
      o_instr_req <= 1'b1;
      o_if_pc     <= pc;
      o_if_instr  <= NOP_INSTR;
      o_if_valid  <= 1'b0;
      hold_pc     <= RESET_PC;
      hold_instr  <= NOP_INSTR;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          o_instr_req <= 1'b1;
        end
        REQ: begin
          if (xfer && i_clk_en) begin
            o_if_pc    <= pc;
            o_if_instr <= i_instr_rdata;
            o_if_valid <= 1'b1;
            pc         <= pc + 32'd4;
          end else if (xfer) begin
            // Data arrived while stalled: park it so the request can drop.
            hold_pc     <= pc;
            hold_instr  <= i_instr_rdata;
            state       <= HOLD;
            o_instr_req <= 1'b0;
          end else if (i_clk_en) begin
            o_if_pc    <= pc;
            o_if_instr <= NOP_INSTR;
            o_if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (i_clk_en) begin
            o_if_pc     <= hold_pc;
            o_if_instr  <= hold_instr;
            o_if_valid  <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= REQ;
            o_instr_req <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_instr_req <= 1'b0;
        end
      endcase
    end
  end
`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_misalign <= 1'b0;
    else o_misalign <= i_flush && (i_branch_target[1:0] != 2'b00);
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage; covers the misalign flag when FETCH_MISALIGN_CHECK_EN is defined.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, ready;
  logic [31:0] tgt, rdata, addr, if_pc, if_instr;
  logic        req, if_valid;
  int          pass_cnt = 0;
  int          total = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction
  assign rdata = mem(addr);
  fetch_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_branch_target(tgt), .o_instr_req(req), .o_instr_addr(addr),
    .i_instr_rdata(rdata), .i_instr_ready(ready), .o_if_pc(if_pc),
    .o_if_instr(if_instr), .o_if_valid(if_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .o_misalign(misalign)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'd0, req}, 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_pc"}, if_pc, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'h13);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; ready = 1'b1; tgt = 32'd0;
    tick();
    chk_reset("rst");
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("c1_req", {31'd0, req}, 32'd1);
    chk("c1_addr", addr, 32'd0);
    chk("c1_valid", {31'd0, if_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq_pc", if_pc, 32'(4 * k));
      chk("seq_instr", if_instr, mem(32'(4 * k)));
      chk("seq_valid", {31'd0, if_valid}, 32'd1);
      chk("seq_addr", addr, 32'(4 * k + 4));
    end
    for (int k = 0; k < 2; k++) begin
      ready = 1'b0;
      repeat (2) begin
        tick();
        chk("ws_bubble", {31'd0, if_valid}, 32'd0);
        chk("ws_nop", if_instr, 32'h13);
        chk("ws_addr", addr, 32'(16 + 4 * k));
      end
      ready = 1'b1;
      tick();
      chk("ws_pc", if_pc, 32'(16 + 4 * k));
      chk("ws_valid", {31'd0, if_valid}, 32'd1);
    end
    flush = 1'b1; tgt = 32'h10;
    tick();
    chk("fl10_addr", addr, 32'h10);
    chk("fl10_valid", {31'd0, if_valid}, 32'd0);
    flush = 1'b0; clk_en = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_req", {31'd0, req}, 32'd0);
      chk("hold_valid", {31'd0, if_valid}, 32'd0);
      chk("hold_instr", if_instr, 32'h13);
    end
    clk_en = 1'b1;
    tick();
    chk("hold_pc", if_pc, 32'h10);
    chk("hold_out", if_instr, mem(32'h10));
    chk("hold_outv", {31'd0, if_valid}, 32'd1);
    chk("hold_next", addr, 32'h14);
    chk("hold_reqon", {31'd0, req}, 32'd1);
    flush = 1'b1; tgt = 32'h40;
    tick();
    chk("fl40_addr", addr, 32'h40);
    flush = 1'b0; ready = 1'b0;
    tick();
    chk("w40_valid", {31'd0, if_valid}, 32'd0);
    flush = 1'b1; tgt = 32'h200; ready = 1'b1;
    tick();
    chk("fl200_addr", addr, 32'h200);
    chk("fl200_drop", {31'd0, if_valid}, 32'd0);
    flush = 1'b0;
    tick();
    chk("fl200_pc", if_pc, 32'h200);
    chk("fl200_instr", if_instr, mem(32'h200));
    chk("fl200_valid", {31'd0, if_valid}, 32'd1);
    flush = 1'b1; tgt = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_next", addr, 32'h0);
    tick();
    chk("wrap_pc0", if_pc, 32'h0);
    chk("wrap_v0", {31'd0, if_valid}, 32'd1);
    flush = 1'b1; tgt = 32'h103;
    tick();
    chk("mis_addr", addr, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_on", {31'd0, misalign}, 32'd1);
`endif
    flush = 1'b0;
    tick();
    chk("mis_pc", if_pc, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_off", {31'd0, misalign}, 32'd0);
`endif
    clk_en = 1'b0;
    tick();
    chk("arst_hold", {31'd0, req}, 32'd0);
    chk("arst_pre", if_pc, 32'h100);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    tick();
    rst_n = 1'b1; clk_en = 1'b1;
    tick();
    chk("rst2_req", {31'd0, req}, 32'd1);
    chk("rst2_addr", addr, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
